// File: rtl/uart_tx_byte_if.sv
// rtl/uart_tx_byte_if.sv - byte handshake between an upstream producer and the uart transmitter
//
// Signals:
//   tx_data  - byte offered by the producer
//   tx_valid - producer has a byte on tx_data
//   tx_ready - transmitter can take a byte this cycle
// Modports: master = producer side, slave = transmitter side.
interface uart_tx_byte_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1/8N2 uart transmitter fed by a valid/ready byte handshake
//
// Ports:
//   clock   - single clock, rising edge
//   reset_n - synchronous active-low reset
//   up      - byte handshake (slave side): tx_data, tx_valid in; tx_ready out
//   tx      - registered serial line, idle high
//   busy    - frame in progress
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (2..65535)
//   STOP_BITS    - number of stop bits (1 or 2)
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_tx_byte_if.slave  up,
  output logic           tx,
  output logic           busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;

  assign bit_end     = (bit_cnt == CNT_LAST);
  // Gated by reset_n so nothing upstream sees a ready while reset is held.
  assign up.tx_ready = (state == IDLE) && reset_n;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      // The line level follows the state one cycle later, which keeps tx a
      // plain flop with no path from the handshake inputs.
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase

      if (state == IDLE) begin
        if (up.tx_valid && up.tx_ready) begin
          shift   <= up.tx_data;
          bit_cnt <= '0;
          bit_idx <= '0;
          state   <= START;
        end
      end else if (!bit_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
        case (state)
          START: begin
            bit_idx <= '0;
            state   <= DATA;
          end
          DATA: begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          STOP: begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// tb/tb_uart_tx_byte.sv - self-checking bench for uart_tx_byte (two parameter sets)
module tb_uart_tx_byte;

  localparam int CPB [2] = '{4, 2};
  localparam int SB  [2] = '{1, 2};

  logic       clock = 1'b0;
  logic       reset_n;
  logic       valid [2];
  logic [7:0] data  [2];
  logic       tx_w  [2];
  logic       busy_w[2];
  logic       rdy_w [2];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_byte_if if0 ();
  uart_tx_byte_if if1 ();
  assign if0.tx_valid = valid[0];
  assign if0.tx_data  = data[0];
  assign if1.tx_valid = valid[1];
  assign if1.tx_data  = data[1];
  assign rdy_w[0]     = if0.tx_ready;
  assign rdy_w[1]     = if1.tx_ready;

  uart_tx_byte #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u0 (
    .clock(clock), .reset_n(reset_n), .up(if0), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx_byte #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u1 (
    .clock(clock), .reset_n(reset_n), .up(if1), .tx(tx_w[1]), .busy(busy_w[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: line level t edges after the accept edge, from the frame
  // layout (start 0, data LSB first, stop 1s), each bit c cycles wide.
  function automatic logic exp_tx(input logic [7:0] b, input int t, input int c);
    int j;
    if (t == 0) return 1'b1;
    j = (t - 1) / c;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return 1'b1;
  endfunction

  // Cycle-by-cycle model, evaluated half a cycle after each rising edge.
  bit         m_act [2] = '{0, 0};
  int         m_t   [2] = '{0, 0};
  logic [7:0] m_dat [2];
  logic       p_valid [2] = '{0, 0};
  logic [7:0] p_data  [2];
  logic       p_rstn = 1'b0;

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      int  flen;
      bit  inf;
      flen = (9 + SB[d]) * CPB[d];
      inf  = m_act[d] && (m_t[d] < flen);
      if (!p_rstn) begin
        m_act[d] = 0;
        m_t[d]   = 0;
      end else if (!inf && p_valid[d]) begin
        m_act[d] = 1;
        m_t[d]   = 0;
        m_dat[d] = p_data[d];
      end else if (m_act[d]) begin
        if (m_t[d] >= flen) m_act[d] = 0;
        else m_t[d]++;
      end
      inf = m_act[d] && (m_t[d] < flen);
      chk($sformatf("model_tx d%0d", d), 32'(tx_w[d]),
          32'(m_act[d] ? exp_tx(m_dat[d], m_t[d], CPB[d]) : 1'b1));
      chk($sformatf("model_busy d%0d", d), 32'(busy_w[d]), 32'(inf));
      chk($sformatf("model_ready d%0d", d), 32'(rdy_w[d]), 32'(!inf && reset_n));
      p_valid[d] = valid[d];
      p_data[d]  = data[d];
    end
    p_rstn = reset_n;
  end

  task automatic start_tx(input int d, input logic [7:0] b);
    int n = 0;
    while (!rdy_w[d] && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'(rdy_w[d]), 32'd1);
    data[d]  = b;
    valid[d] = 1'b1;
    @(posedge clock); #1;
    valid[d] = 1'b0;
    data[d]  = 8'h3C;
  endtask

  // Sends a byte, scribbles on tx_data while busy, samples mid-bit and
  // records the edge (relative to accept) on which tx_ready returns.
  task automatic send_capture(input int d, input logic [7:0] b, input int nbits,
                              output logic [10:0] rx, output int lat);
    int c;
    int j;
    c   = CPB[d];
    rx  = '1;
    lat = -1;
    start_tx(d, b);
    for (int e = 1; e <= nbits * c + 2; e++) begin
      @(posedge clock); #1;
      data[d] = 8'($urandom);
      @(negedge clock);
      j = (e - 1) / c;
      if (j < nbits && ((e - 1) % c) == c / 2) rx[j] = tx_w[d];
      if (lat < 0 && rdy_w[d]) lat = e;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic [9:0] bits;
  } vec_t;

  vec_t        vt [5];
  logic [10:0] rx;
  int          lat;
  int          k1;

  initial begin
    vt[0] = '{8'hA5, 10'b1_10100101_0};
    vt[1] = '{8'h00, 10'b1_00000000_0};
    vt[2] = '{8'hFF, 10'b1_11111111_0};
    vt[3] = '{8'h81, 10'b1_10000001_0};
    vt[4] = '{8'h55, 10'b1_01010101_0};

    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b1;
      data[d]  = 8'hC3;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rst_tx", 32'(tx_w[0]), 32'd1);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_ready", 32'(rdy_w[0]), 32'd0);
    end
    @(posedge clock); #1;
    reset_n  = 1'b1;
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    @(negedge clock);
    chk("rel_ready", 32'(rdy_w[0]), 32'd1);
    chk("rel_busy", 32'(busy_w[0]), 32'd0);
    chk("rel_tx", 32'(tx_w[0]), 32'd1);

    for (int i = 0; i < 5; i++) begin
      send_capture(0, vt[i].b, 10, rx, lat);
      chk($sformatf("vec_bits %02h", vt[i].b), 32'(rx[9:0]), 32'(vt[i].bits));
      chk($sformatf("vec_len %02h", vt[i].b), 32'(lat), 32'd40);
    end

    // back-to-back with tx_valid held high
    @(posedge clock); #1;
    data[0]  = 8'h00;
    valid[0] = 1'b1;
    @(posedge clock); #1;
    k1      = cyc;
    data[0] = 8'hFF;
    for (int n = 0; n < 200 && !rdy_w[0]; n++) begin
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    valid[0] = 1'b0;
    chk("b2b_spacing", 32'(cyc - k1), 32'd41);
    repeat (45) @(posedge clock);
    #1;

    // reset during data bit 3
    start_tx(0, 8'hF0);
    repeat (18) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrst_tx", 32'(tx_w[0]), 32'd1);
    chk("midrst_busy", 32'(busy_w[0]), 32'd0);
    send_capture(0, 8'h55, 10, rx, lat);
    chk("after_rst_bits", 32'(rx[9:0]), 32'(10'b1_01010101_0));

    // two stop bits, 2 clocks per bit
    send_capture(1, 8'h01, 11, rx, lat);
    chk("stop2_bits", 32'(rx), 32'(11'b11_00000001_0));
    chk("stop2_len", 32'(lat), 32'd22);

    // randomized traffic with occasional resets, checked by the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      reset_n = ($urandom_range(0, 499) != 0);
      for (int d = 0; d < 2; d++) begin
        valid[d] = ($urandom_range(0, 3) != 0);
        data[d]  = 8'($urandom);
      end
    end
    @(posedge clock); #1;
    reset_n  = 1'b1;
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    repeat (60) @(posedge clock);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
